// File: rtl/main_mem_responder.sv
// main_mem_responder: word-wide main memory behind the cache-fill interface.
//   Accepts single-word writes (absorbed in one cycle, no response) and
//   block-fill reads. A read returns one aligned block of BEATS 16-bit words
//   in ascending order, with the first beat arriving LATENCY cycles after
//   the request is accepted.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_write        request strobe and type (1 = write)
//   req_addr/req_wdata         byte address (bit 0 ignored), write data
//   req_ready                  high only while idle
//   rsp_valid/rsp_data/
//   rsp_addr/rsp_last          registered burst beat, last flag on final beat
module main_mem_responder #(
  parameter int LATENCY = 4,
  parameter int BEATS   = 8,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last
);

  localparam int LB    = $clog2(BEATS);
  localparam int BW    = (LB > 0) ? LB : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WORDS = 1 << (ADDR_W - 1);
  // Byte offset bits inside one block (word offset plus the ignored bit 0).
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((2 * BEATS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;

  logic [15:0]       mem [WORDS];

  // Beat load path: which beat index (if any) goes to the output regs.
  logic              ld;
  logic [BW-1:0]     ld_idx;
  logic [ADDR_W-1:0] ld_addr;

  logic unused_addr_bit0;
  assign unused_addr_bit0 = req_addr[0];

  assign req_ready = (state_q == S_IDLE);

  // Block is aligned, so OR-ing in the offset can never carry out of it.
  assign ld_addr = base_q | (ADDR_W'(ld_idx) << 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    base_d      = base_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    ld          = 1'b0;
    ld_idx      = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !req_write) begin
          base_d  = req_addr & ~BLK_MASK;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_BURST;
          beat_d  = '0;
          ld      = 1'b1;
          ld_idx  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BURST: begin
        if (beat_q == BW'(BEATS - 1)) begin
          state_d     = S_IDLE;
          beat_d      = '0;
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
        end else begin
          beat_d = beat_q + 1'b1;
          ld     = 1'b1;
          ld_idx = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ld) begin
      rsp_valid_d = 1'b1;
      rsp_last_d  = (ld_idx == BW'(BEATS - 1));
      rsp_addr_d  = ld_addr;
      rsp_data_d  = mem[ld_addr[ADDR_W-1:1]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  // Storage is not reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready && req_write)
      mem[req_addr[ADDR_W-1:1]] <= req_wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized bench for main_mem_responder against a timestamped scoreboard:
// every accepted read schedules its BEATS expected beats at absolute edge
// numbers, and every negedge compares the DUT outputs to that schedule.
module tb_main_mem_responder;
  localparam int LAT = 4;
  localparam int BTS = 8;
  localparam int AW  = 16;

  logic          gclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_last;
  logic [15:0]   rsp_data;
  logic [AW-1:0] rsp_addr;

  always #5 gclk = ~gclk;

  main_mem_responder #(.LATENCY(LAT), .BEATS(BTS), .ADDR_W(AW)) dut (
    .clk(gclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last)
  );

  typedef struct {
    int          e;
    logic [15:0] a;
    logic [15:0] d;
    logic        l;
  } beat_t;

  int          n_vec = 0, n_err = 0;
  int          edge_n = 0, busy_until = 0;
  logic        acc_flag = 1'b0;
  logic [15:0] mem_m [int];
  beat_t       expq [$];
  beat_t       cur;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Reference model: acceptance, memory image and beat schedule.
  always @(posedge gclk) begin
    acc_flag = 1'b0;
    if (rst_n && req_valid && (edge_n >= busy_until)) begin
      acc_flag = 1'b1;
      if (req_write) mem_m[int'(req_addr >> 1)] = req_wdata;
      else begin
        int base;
        base = int'(req_addr) & ~(2 * BTS - 1);
        for (int i = 0; i < BTS; i++) begin
          beat_t b;
          b.e = edge_n + 1 + LAT + i;
          b.a = 16'(base + 2 * i);
          b.d = mem_m.exists((base + 2 * i) >> 1) ? mem_m[(base + 2 * i) >> 1] : 16'hxxxx;
          b.l = (i == BTS - 1);
          expq.push_back(b);
        end
        busy_until = edge_n + 1 + LAT + BTS;
      end
    end
    edge_n++;
  end

  always @(negedge rst_n) begin
    expq.delete();
    busy_until = 0;
  end

  always @(negedge gclk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_last",  rsp_last,  0);
      chk("rst_data",  rsp_data,  0);
      chk("rst_addr",  rsp_addr,  0);
    end else begin
      chk("req_ready", req_ready, (edge_n >= busy_until));
      if (expq.size() > 0 && expq[0].e == edge_n) begin
        cur = expq.pop_front();
        chk("beat_valid", rsp_valid, 1);
        chk("beat_addr",  rsp_addr,  cur.a);
        chk("beat_data",  rsp_data,  cur.d);
        chk("beat_last",  rsp_last,  cur.l);
      end else begin
        chk("idle_valid", rsp_valid, 0);
        chk("idle_last",  rsp_last,  0);
      end
    end
  end

  // Present a request and hold it until the model says it was accepted.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    do begin
      @(posedge gclk); #1; n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  int blks [8];

  initial begin
    blks[0] = 'h0020; blks[1] = 'h0030; blks[2] = 'h0040; blks[3] = 'h0100;
    blks[4] = 'hFFF0;
    for (int i = 5; i < 8; i++) blks[i] = int'($urandom_range(0, 16'hFFFF)) & 'hFFF0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge gclk);
    #1 rst_n = 1'b1;

    // Preload every block the bench will read.
    for (int b = 0; b < 8; b++)
      for (int w = 0; w < BTS; w++)
        do_req(1'b1, 16'(blks[b] + 2 * w), 16'($urandom));

    // Write then fill on the next cycle.
    do_req(1'b1, 16'h0024, 16'hBEEF);
    do_req(1'b0, 16'h002A, 16'h0000);
    repeat (14) @(posedge gclk);
    #1;

    // Backpressure: second read held while the first burst runs.
    do_req(1'b0, 16'h0040, 16'h0000);
    do_req(1'b0, 16'h0100, 16'h0000);
    repeat (14) @(posedge gclk);
    #1;

    // Odd address write, then fill.
    do_req(1'b1, 16'h0031, 16'h1234);
    do_req(1'b0, 16'h0030, 16'h0000);
    // Top-of-memory block.
    do_req(1'b0, 16'hFFF6, 16'h0000);
    repeat (14) @(posedge gclk);
    #1;

    // Random mix of writes and reads inside the preloaded blocks.
    for (int k = 0; k < 60; k++) begin
      int blk;
      blk = blks[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1)
        do_req(1'b1, 16'(blk + int'($urandom_range(0, 15))), 16'($urandom));
      else
        do_req(1'b0, 16'(blk + int'($urandom_range(0, 15))), 16'h0000);
      repeat ($urandom_range(0, 3)) @(posedge gclk);
      #1;
    end
    repeat (14) @(posedge gclk);
    #1;

    // Reset after beat 3 of a burst, then re-issue the fill.
    do_req(1'b0, 16'h0020, 16'h0000);
    repeat (LAT + 3) @(posedge gclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_last",  rsp_last,  0);
    chk("midrst_ready", req_ready, 1);
    @(negedge gclk);
    @(negedge gclk);
    #1 rst_n = 1'b1;
    do_req(1'b0, 16'h0020, 16'h0000);
    repeat (16) @(posedge gclk);
    #1;

    chk("drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
